multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset core. Steps one instruction at a time through
//  FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file, ALU-latch and memory strobes.
//  Handles variable-latency imem/dmem through req/ready handshakes.
//  Consumes the instruction decoder's jump_type, we_dmem, we_regfile and lw_flag outputs.
// PARAMETERS
//  CNT_W    32   width of the retired-instruction counter
//  TIMEOUT  64   max cycles waiting on imem/dmem ready before ERR; 0 disables the timeout
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  enable         in   1      run request; sampled only at instruction boundaries
//  jump_type      in   3      decoder: 0 none, 1 beq, 2 jr, 3 jal, 4 j
//  we_dmem        in   1      decoder: instruction is a store
//  we_regfile     in   1      decoder: instruction writes the register file
//  lw_flag        in   2      decoder: 0 ALU result, 1 dmem load, 2 PC+4 (jal)
//  alu_zero       in   1      ALU zero flag; valid in EXEC
//  imem_ready     in   1      imem data valid; completes a fetch
//  dmem_ready     in   1      dmem access complete
//  imem_req       out  1      fetch request
//  ir_we          out  1      latch instruction register
//  alu_out_we     out  1      latch ALU result register
//  dmem_req       out  1      data-memory request
//  dmem_we        out  1      data-memory write qualifier
//  rf_we          out  1      register-file write strobe
//  pc_we          out  1      update PC; marks instruction retire
//  pc_sel         out  2      0 PC+4, 1 PC+4+(imm<<2), 2 rs1 (jr), 3 {PC+4[31:28],addr,2'b00}
//  busy           out  1      state != IDLE
//  err            out  1      sticky timeout error
//  state_o        out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=7
//  retired        out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, err=0, retired=0, wait counter=0, all strobes 0.
//    Reset mid-access aborts it immediately; no strobe is produced on the reset edge.
//  - Strobes are combinational from the state register plus the inputs named below.
//    imem_req and dmem_req depend on state only (no path from ready to req).
//  - IDLE: enable=1 -> FETCH; otherwise stay.
//  - FETCH: imem_req=1 held until imem_ready. On imem_ready: ir_we=1 that cycle -> DECODE.
//  - DECODE: 1 cycle, no strobes (decoder and regfile read settle) -> EXEC.
//  - EXEC: alu_out_we=1. Next state:
//      * lw_flag==1 or we_dmem -> MEM.
//      * else we_regfile -> WB.
//      * else retire here (pc_we=1).
//  - MEM: dmem_req=1, dmem_we=we_dmem, held until dmem_ready. On dmem_ready:
//      * load -> WB.
//      * store -> retire here (pc_we=1).
//  - WB: rf_we=1 and pc_we=1 for exactly 1 cycle (jal writes PC+4 to r31 via lw_flag=2); retire.
//  - Retire cycle:
//      * pc_we=1 and retired+1; counter wraps 2^CNT_W-1 -> 0.
//      * pc_sel from jump_type: beq -> 1 if alu_zero else 0; jr -> 2; jal/j -> 3; none -> 0.
//      * beq retires in EXEC, so it always uses the current alu_zero.
//      * Next state FETCH if enable=1, else IDLE. An instruction in flight always completes.
//  - Undefined decode (we_regfile=we_dmem=0, jump_type=0): behaves as NOP, retires from EXEC, pc_sel=0.
//  - Cycle counts with zero-wait memory (ready=1 in the first wait cycle):
//      * j/jr/beq/NOP: 3 cycles; R-type/addi/slti/jal: 4; sw: 4; lw: 5.
//  - Timeout (TIMEOUT>0):
//      * Wait counter clears on entering FETCH or MEM and increments each waiting cycle.
//      * TIMEOUT cycles with no ready -> ERR.
//      * ready in the same cycle as the limit counts as success.
//  - ERR: all strobes 0, err=1, busy=1; exited only by reset.
//  - Signal validity: jump_type, we_*, lw_flag are valid from DECODE onward (IR held).
//    alu_zero is sampled only in EXEC.
// TESTING
//  1. rst_n=0 mid-MEM with dmem_req=1 -> next cycle all strobes 0, state_o=0, retired=0, err=0.
//  2. enable=1, zero-wait memories, add then lw -> pc_we pulses 4 then 5 cycles apart;
//     rf_we in WB of each; retired=2.
//  3. beq with alu_zero=1 -> pc_sel=1 with pc_we in EXEC;
//     beq with alu_zero=0 -> pc_sel=0; neither asserts rf_we or dmem_req.
//  4. sw with dmem_ready delayed 3 cycles -> dmem_req and dmem_we high 4 cycles, then pc_we;
//     no rf_we.
//  5. TIMEOUT=4, imem_ready stuck 0 -> ERR after 4 FETCH cycles, err=1 sticky;
//     a later imem_ready has no effect.
//  6. enable dropped during EXEC of jal -> WB completes (rf_we=1, pc_sel=3) -> IDLE; busy=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS-subset core. Walks one instruction at a
//   time through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file,
//   ALU-latch and memory strobes. Variable-latency instruction and data
//   memories are handled with req/ready handshakes guarded by a wait timeout.
//
// Parameters
//   CNT_W    width of the retired-instruction counter
//   TIMEOUT  max wait cycles on imem/dmem ready before ERR (0 = no timeout)
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   enable          run request, sampled only at instruction boundaries
//   jump_type       decoder jump class: 0 none, 1 beq, 2 jr, 3 jal, 4 j
//   we_dmem         decoder: store
//   we_regfile      decoder: writes the register file
//   lw_flag         decoder writeback source: 0 ALU, 1 dmem load, 2 PC+4
//   alu_zero        ALU zero flag, used in EXEC only
//   imem_ready      fetch complete
//   dmem_ready      data access complete
//   imem_req        fetch request
//   ir_we           latch instruction register
//   alu_out_we      latch ALU result register
//   dmem_req        data-memory request
//   dmem_we         data-memory write qualifier
//   rf_we           register-file write strobe
//   pc_we           PC update, marks instruction retire
//   pc_sel          next-PC source: 0 PC+4, 1 branch, 2 rs1, 3 jump target
//   busy            sequencer not idle
//   err             sticky memory timeout error
//   state_o         encoded state (IDLE=0 .. WB=5, ERR=7)
//   retired         completed-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [2:0]       jump_type,
   input  logic             we_dmem,
   input  logic             we_regfile,
   input  logic [1:0]       lw_flag,
   input  logic             alu_zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             alu_out_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_ERR    = 3'd7
   } state_t;

   // The wait counter only has to reach TIMEOUT-1; the limit cycle itself
   // decides between success (ready) and ERR.
   localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LIMIT_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [WAIT_W-1:0] LIMIT = LIMIT_I[WAIT_W-1:0];

   state_t             state_r;
   state_t             state_next_s;
   logic [WAIT_W-1:0]  wait_cnt_r;
   logic [CNT_W-1:0]   retired_r;
   logic               err_r;
   logic               retire_s;
   logic               wait_inc_s;
   logic               enter_wait_s;
   logic               timeout_hit_s;

   assign timeout_hit_s = (TIMEOUT > 0) && (wait_cnt_r == LIMIT);

   // Next-state and strobe decode from the state register plus inputs.
   always_comb begin
      state_next_s = state_r;
      imem_req     = 1'b0;
      ir_we        = 1'b0;
      alu_out_we   = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      rf_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      retire_s     = 1'b0;
      wait_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_next_s = ST_FETCH;
            else        state_next_s = ST_IDLE;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we        = 1'b1;
               state_next_s = ST_DECODE;
            end else if (timeout_hit_s) begin
               state_next_s = ST_ERR;
            end else begin
               wait_inc_s   = 1'b1;
            end
         end
         ST_DECODE: state_next_s = ST_EXEC;
         ST_EXEC: begin
            alu_out_we = 1'b1;
            if ((lw_flag == 2'd1) || we_dmem) state_next_s = ST_MEM;
            else if (we_regfile)              state_next_s = ST_WB;
            else                              retire_s     = 1'b1;
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = we_dmem;
            if (dmem_ready) begin
               // A store finishes here; a load still has its writeback.
               if (we_dmem) retire_s     = 1'b1;
               else         state_next_s = ST_WB;
            end else if (timeout_hit_s) begin
               state_next_s = ST_ERR;
            end else begin
               wait_inc_s   = 1'b1;
            end
         end
         ST_WB: begin
            rf_we    = 1'b1;
            retire_s = 1'b1;
         end
         ST_ERR:  state_next_s = ST_ERR;
         default: state_next_s = ST_ERR;
      endcase

      if (retire_s) begin
         pc_we = 1'b1;
         case (jump_type)
            3'd1:    pc_sel = alu_zero ? 2'd1 : 2'd0;
            3'd2:    pc_sel = 2'd2;
            3'd3,
            3'd4:    pc_sel = 2'd3;
            default: pc_sel = 2'd0;
         endcase
         if (enable) state_next_s = ST_FETCH;
         else        state_next_s = ST_IDLE;
      end else begin
         pc_sel = 2'd0;
      end
   end

   assign enter_wait_s = (state_next_s != state_r) &&
                         ((state_next_s == ST_FETCH) || (state_next_s == ST_MEM));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_next_s;
   end

   // Memory wait counter: cleared on entry to FETCH/MEM, counts stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          wait_cnt_r <= '0;
      else if (enter_wait_s)               wait_cnt_r <= '0;
      else if (wait_inc_s && (TIMEOUT > 0)) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      else                                 wait_cnt_r <= wait_cnt_r;
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        retired_r <= '0;
      else if (retire_s) retired_r <= retired_r + CNT_W'(1);
      else               retired_r <= retired_r;
   end

   // Sticky error flag, set on entry to ERR; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     err_r <= 1'b0;
      else if (state_next_s == ST_ERR) err_r <= 1'b1;
      else                            err_r <= err_r;
   end

   assign state_o = state_r;
   assign busy    = (state_r != ST_IDLE);
   assign err     = err_r;
   assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  jump_type = 3'd0;
   logic        we_dmem = 1'b0;
   logic        we_regfile = 1'b0;
   logic [1:0]  lw_flag = 2'd0;
   logic        alu_zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, ir_we, alu_out_we, dmem_req, dmem_we, rf_we, pc_we;
   logic [1:0]  pc_sel;
   logic        busy, err;
   logic [2:0]  state_o;
   logic [31:0] retired;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_retired = 0;

   localparam logic [2:0] I = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3, M = 3'd4, W = 3'd5, X = 3'd7;
   localparam logic [6:0] N    = 7'b0000000;
   localparam logic [6:0] IREQ = 7'b1000000;
   localparam logic [6:0] IRWE = 7'b0100000;
   localparam logic [6:0] ALU  = 7'b0010000;
   localparam logic [6:0] DREQ = 7'b0001000;
   localparam logic [6:0] DWE  = 7'b0000100;
   localparam logic [6:0] RF   = 7'b0000010;
   localparam logic [6:0] PC   = 7'b0000001;

   multicycle_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .jump_type(jump_type),
      .we_dmem(we_dmem), .we_regfile(we_regfile), .lw_flag(lw_flag),
      .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_we(ir_we), .alu_out_we(alu_out_we),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .busy(busy), .err(err), .state_o(state_o), .retired(retired)
   );

   always #5 clk = ~clk;

   // stimulus word: {enable, imem_ready, dmem_ready, alu_zero, jump_type, we_dmem, we_regfile, lw_flag}
   function automatic logic [10:0] mk(input logic en, input logic ir, input logic dr, input logic az,
                                      input logic [2:0] jt, input logic wd, input logic wr,
                                      input logic [1:0] lw);
      return {en, ir, dr, az, jt, wd, wr, lw};
   endfunction

   function automatic logic [11:0] mkx(input logic [2:0] s, input logic [6:0] strb, input logic [1:0] sel);
      return {s, strb, sel};
   endfunction

   function automatic logic [11:0] obs();
      return {state_o, imem_req, ir_we, alu_out_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel};
   endfunction

   task automatic drive(input logic [10:0] v);
      {enable, imem_ready, dmem_ready, alu_zero, jump_type, we_dmem, we_regfile, lw_flag} = v;
   endtask

   task automatic test_reset();
      drive(11'd0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (obs() !== mkx(I, N, 2'd0) || retired !== 32'd0 || err !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: obs=%h ret=%0d err=%b busy=%b, expected obs=%h ret=0 err=0 busy=0",
                  obs(), retired, err, busy, mkx(I, N, 2'd0));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add_lw();
      logic [10:0] stim [11];
      logic [11:0] expv [11];
      stim = '{mk(1,1,1,0,3'd0,0,1,2'd0), mk(1,1,1,0,3'd0,0,1,2'd0), mk(1,1,1,0,3'd0,0,1,2'd0),
               mk(1,1,1,0,3'd0,0,1,2'd0), mk(1,1,1,0,3'd0,0,1,2'd0), mk(1,1,1,0,3'd0,0,1,2'd1),
               mk(1,1,1,0,3'd0,0,1,2'd1), mk(1,1,1,0,3'd0,0,1,2'd1), mk(1,1,1,0,3'd0,0,1,2'd1),
               mk(0,1,1,0,3'd0,0,1,2'd1), mk(0,1,1,0,3'd0,0,1,2'd1)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU,2'd0),
               mkx(W,RF|PC,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU,2'd0),
               mkx(M,DREQ,2'd0), mkx(W,RF|PC,2'd0), mkx(I,N,2'd0)};
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i] || busy !== (expv[i][11:9] != I)) begin
            tests_failed++;
            $display("FAIL add_lw row %0d: got %h busy=%b, expected %h", i, obs(), busy, expv[i]);
         end
      end
      exp_retired += 2;
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL add_lw retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_beq();
      logic [10:0] stim [8];
      logic [11:0] expv [8];
      stim = '{mk(1,1,1,1,3'd1,0,0,2'd0), mk(1,1,1,1,3'd1,0,0,2'd0), mk(1,1,1,1,3'd1,0,0,2'd0),
               mk(1,1,1,1,3'd1,0,0,2'd0), mk(1,1,1,0,3'd1,0,0,2'd0), mk(1,1,1,0,3'd1,0,0,2'd0),
               mk(0,1,1,0,3'd1,0,0,2'd0), mk(0,1,1,0,3'd1,0,0,2'd0)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU|PC,2'd1),
               mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU|PC,2'd0), mkx(I,N,2'd0)};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i]) begin
            tests_failed++;
            $display("FAIL beq row %0d: got %h, expected %h", i, obs(), expv[i]);
         end
      end
      exp_retired += 2;
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL beq retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_sw_wait();
      logic [10:0] stim [9];
      logic [11:0] expv [9];
      stim = '{mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0),
               mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0),
               mk(1,1,0,0,3'd0,1,0,2'd0), mk(0,1,1,0,3'd0,1,0,2'd0), mk(0,1,1,0,3'd0,1,0,2'd0)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU,2'd0),
               mkx(M,DREQ|DWE,2'd0), mkx(M,DREQ|DWE,2'd0), mkx(M,DREQ|DWE,2'd0),
               mkx(M,DREQ|DWE|PC,2'd0), mkx(I,N,2'd0)};
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i] || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_wait row %0d: got %h err=%b, expected %h err=0", i, obs(), err, expv[i]);
         end
      end
      exp_retired += 1;
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL sw_wait retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_jal_drop();
      logic [10:0] stim [6];
      logic [11:0] expv [6];
      stim = '{mk(1,1,1,0,3'd3,0,1,2'd2), mk(1,1,1,0,3'd3,0,1,2'd2), mk(1,1,1,0,3'd3,0,1,2'd2),
               mk(0,1,1,0,3'd3,0,1,2'd2), mk(0,1,1,0,3'd3,0,1,2'd2), mk(0,1,1,0,3'd3,0,1,2'd2)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU,2'd0),
               mkx(W,RF|PC,2'd3), mkx(I,N,2'd0)};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i] || busy !== (expv[i][11:9] != I)) begin
            tests_failed++;
            $display("FAIL jal_drop row %0d: got %h busy=%b, expected %h", i, obs(), busy, expv[i]);
         end
      end
      exp_retired += 1;
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL jal_drop retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] stim [11];
      logic [11:0] expv [11];
      stim = '{mk(1,1,1,1,3'd2,0,0,2'd0), mk(1,1,1,1,3'd2,0,0,2'd0), mk(1,1,1,1,3'd2,0,0,2'd0),
               mk(1,1,1,1,3'd2,0,0,2'd0), mk(1,1,1,0,3'd4,0,0,2'd0), mk(1,1,1,0,3'd4,0,0,2'd0),
               mk(1,1,1,0,3'd4,0,0,2'd0), mk(1,1,1,1,3'd0,0,0,2'd0), mk(1,1,1,1,3'd0,0,0,2'd0),
               mk(0,1,1,1,3'd0,0,0,2'd0), mk(0,1,1,1,3'd0,0,0,2'd0)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU|PC,2'd2),
               mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU|PC,2'd3),
               mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU|PC,2'd0), mkx(I,N,2'd0)};
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i]) begin
            tests_failed++;
            $display("FAIL back_to_back row %0d: got %h, expected %h", i, obs(), expv[i]);
         end
      end
      exp_retired += 3;
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL back_to_back retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_timeout();
      logic [10:0] stim [8];
      logic [11:0] expv [8];
      stim = '{mk(1,0,0,0,3'd0,0,1,2'd0), mk(1,0,0,0,3'd0,0,1,2'd0), mk(1,0,0,0,3'd0,0,1,2'd0),
               mk(1,0,0,0,3'd0,0,1,2'd0), mk(1,0,0,0,3'd0,0,1,2'd0), mk(1,0,0,0,3'd0,0,1,2'd0),
               mk(1,1,1,0,3'd0,0,1,2'd0), mk(0,1,1,0,3'd0,0,1,2'd0)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ,2'd0), mkx(F,IREQ,2'd0), mkx(F,IREQ,2'd0),
               mkx(F,IREQ,2'd0), mkx(X,N,2'd0), mkx(X,N,2'd0), mkx(X,N,2'd0)};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i] || err !== (expv[i][11:9] == X) || busy !== (expv[i][11:9] != I)) begin
            tests_failed++;
            $display("FAIL timeout row %0d: got %h err=%b busy=%b, expected %h", i, obs(), err, busy, expv[i]);
         end
      end
      tests_run++;
      if (retired !== 32'(exp_retired)) begin
         tests_failed++;
         $display("FAIL timeout retired: got %0d, expected %0d", retired, exp_retired);
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [10:0] stim [5];
      logic [11:0] expv [5];
      // leave ERR through reset first
      @(posedge clk); #1;
      drive(11'd0);
      rst_n = 1'b0; #1;
      tests_run++;
      if (obs() !== mkx(I, N, 2'd0) || err !== 1'b0 || retired !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_from_err: got %h err=%b ret=%0d, expected %h err=0 ret=0",
                  obs(), err, retired, mkx(I, N, 2'd0));
      end
      rst_n = 1'b1;
      stim = '{mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0),
               mk(1,1,0,0,3'd0,1,0,2'd0), mk(1,1,0,0,3'd0,1,0,2'd0)};
      expv = '{mkx(I,N,2'd0), mkx(F,IREQ|IRWE,2'd0), mkx(D,N,2'd0), mkx(E,ALU,2'd0),
               mkx(M,DREQ|DWE,2'd0)};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; drive(stim[i]); #1;
         tests_run++;
         if (obs() !== expv[i]) begin
            tests_failed++;
            $display("FAIL reset_mid_mem row %0d: got %h, expected %h", i, obs(), expv[i]);
         end
      end
      rst_n = 1'b0; #1;
      tests_run++;
      if (obs() !== mkx(I, N, 2'd0) || retired !== 32'd0 || err !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_mem async: got %h ret=%0d err=%b busy=%b, expected %h",
                  obs(), retired, err, busy, mkx(I, N, 2'd0));
      end
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== mkx(I, N, 2'd0) || retired !== 32'd0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_mem edge: got %h ret=%0d err=%b, expected %h",
                  obs(), retired, err, mkx(I, N, 2'd0));
      end
      drive(11'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (obs() !== mkx(I, N, 2'd0)) begin
         tests_failed++;
         $display("FAIL reset_mid_mem idle: got %h, expected %h", obs(), mkx(I, N, 2'd0));
      end
   endtask

   initial begin
      test_reset();
      test_add_lw();
      test_beq();
      test_sw_wait();
      test_jal_drop();
      test_back_to_back();
      test_timeout();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
